// File: rtl/iz_pkg.sv
// rtl/iz_pkg.sv - shared types and constants for the IZ parameter serial link
`timescale 1ns/1ps
package iz_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_SHIFT    = 2'd2,
        S_GAP      = 2'd3
    } ser_state_e;

    localparam int CODE_W     = 8;
    localparam int FRAME_BITS = 32;

    // Regular-spiking codes, also consumed by the loader's bench
    localparam logic [CODE_W-1:0] RS_CODE_A = 8'h00;
    localparam logic [CODE_W-1:0] RS_CODE_B = 8'hA0;
    localparam logic [CODE_W-1:0] RS_CODE_C = 8'h64;
    localparam logic [CODE_W-1:0] RS_CODE_D = 8'h20;

endpackage

// File: rtl/iz_piso32.sv
// rtl/iz_piso32.sv - 32-bit parallel-load, MSB-first shift register
`timescale 1ns/1ps
module iz_piso32
    import iz_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [FRAME_BITS-1:0] data_i,
    output logic                  msb_o
);

    logic [FRAME_BITS-1:0] shreg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else if (en_i) begin
            if (load_i) begin
                shreg_q <= data_i;
            end else if (shift_i) begin
                shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign msb_o = shreg_q[FRAME_BITS-1];

endmodule

// File: rtl/iz_param_serializer.sv
// rtl/iz_param_serializer.sv - framed serial transmitter of a,b,c,d IZ parameter codes
// Optional IZ_SER_DEFAULT_EN adds use_default to send the regular-spiking code set.
`timescale 1ns/1ps
module iz_param_serializer #(
    parameter int CODE_W  = 8,
    parameter int N_CODES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [CODE_W-1:0] code_a,
    input  logic [CODE_W-1:0] code_b,
    input  logic [CODE_W-1:0] code_c,
    input  logic [CODE_W-1:0] code_d,
`ifdef IZ_SER_DEFAULT_EN
    input  logic              use_default,
`endif
    output logic              serial_data_out,
    output logic              load_enable_out,
    output logic              busy,
    output logic              done
);

    import iz_pkg::*;

    localparam int FRAME_W = N_CODES * CODE_W;
    localparam int CNT_W   = $clog2(FRAME_BITS);

    ser_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load, shift, frame_msb;
    logic [FRAME_W-1:0] frame_load;
    logic               sd_q, sd_d, le_q, le_d, busy_q, busy_d, done_q, done_d;

`ifdef IZ_SER_DEFAULT_EN
    assign frame_load = use_default ? {RS_CODE_A, RS_CODE_B, RS_CODE_C, RS_CODE_D}
                                    : {code_a, code_b, code_c, code_d};
`else
    assign frame_load = {code_a, code_b, code_c, code_d};
`endif

    iz_piso32 u_piso (
        .clk     (clk),
        .reset   (reset),
        .en_i    (enable),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (frame_load),
        .msb_o   (frame_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shift = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so they trail it by one edge
    always_comb begin
        sd_d   = 1'b0;
        le_d   = 1'b0;
        busy_d = (state_q != S_IDLE);
        done_d = 1'b0;
        case (state_q)
            S_PREAMBLE: le_d = 1'b1;
            S_SHIFT: begin
                le_d = 1'b1;
                sd_d = frame_msb;
            end
            S_GAP:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sd_q   <= 1'b0;
            le_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (enable) begin
            sd_q   <= sd_d;
            le_q   <= le_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign serial_data_out = sd_q;
    assign load_enable_out = le_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_iz_param_serializer.sv
// tb/tb_iz_param_serializer.sv - randomized self-checking bench for iz_param_serializer
`timescale 1ns/1ps
module tb_iz_param_serializer;

    logic       clk = 1'b0;
    logic       reset, enable, start;
    logic [7:0] code_a, code_b, code_c, code_d;
    logic       use_default;
    logic       serial_data_out, load_enable_out, busy, done;

    int n_vec = 0;
    int n_bad = 0;

    int          m_pos;
    logic [31:0] m_frame;
    logic [3:0]  m_out;

    always #5 clk = ~clk;

    iz_param_serializer dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .start           (start),
        .code_a          (code_a),
        .code_b          (code_b),
        .code_c          (code_c),
        .code_d          (code_d),
`ifdef IZ_SER_DEFAULT_EN
        .use_default     (use_default),
`endif
        .serial_data_out (serial_data_out),
        .load_enable_out (load_enable_out),
        .busy            (busy),
        .done            (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] req_frame();
`ifdef IZ_SER_DEFAULT_EN
        if (use_default) return 32'h00A06420;
`endif
        return {code_a, code_b, code_c, code_d};
    endfunction

    // Model: m_pos counts enabled edges since the start edge; outputs packed {sd, le, busy, done}
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_pos = -1;
            m_out = 4'b0000;
        end else if (enable) begin
            if (m_pos < 0 || m_pos == 34) begin
                m_out = 4'b0000;
                if (start) begin
                    m_pos   = 0;
                    m_frame = req_frame();
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
                if (m_pos == 1)       m_out = 4'b0110;
                else if (m_pos <= 33) m_out = {m_frame[33 - m_pos], 3'b110};
                else                  m_out = 4'b0011;
            end
        end
        @(negedge clk);
        chk("outs", {28'd0, serial_data_out, load_enable_out, busy, done}, {28'd0, m_out});
    endtask

    task automatic rand_codes();
        code_a = 8'($urandom); code_b = 8'($urandom);
        code_c = 8'($urandom); code_d = 8'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; enable = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] stream;
        int done_at, nd, rise1, rise2;
        logic prev_le;

        reset = 1'b1; enable = 1'b1; start = 1'b0; use_default = 1'b0;
        code_a = 0; code_b = 0; code_c = 0; code_d = 0;
        m_pos = -1; m_out = 4'b0000; m_frame = 0;
        @(negedge clk);
        do_reset();
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Directed frame 0xA53CF00F
        code_a = 8'hA5; code_b = 8'h3C; code_c = 8'hF0; code_d = 8'h0F; start = 1'b1;
        step();
        start = 1'b0; rand_codes();
        stream = 0; done_at = -1;
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k >= 2 && k <= 33) stream = {stream[30:0], serial_data_out};
            if (done && done_at < 0) done_at = k;
            if (k == 35) chk("busy_T35", {31'd0, busy}, 32'd0);
        end
        chk("stream_a53c", stream, 32'hA53CF00F);
        chk("done_latency", done_at, 34);

        // Start held for three frames
        rand_codes(); start = 1'b1;
        step();
        nd = 0; rise1 = -1; rise2 = -1; prev_le = 1'b0;
        for (int k = 1; k <= 105; k++) begin
            step();
            if (done) nd++;
            if (load_enable_out && !prev_le) begin
                if (rise1 < 0) rise1 = k; else if (rise2 < 0) rise2 = k;
            end
            prev_le = load_enable_out;
        end
        start = 1'b0;
        for (int k = 0; k < 40; k++) step();
        chk("held_dones", nd, 3);
        chk("held_period", rise2 - rise1, 35);

        // Start pulse mid-frame is ignored
        rand_codes(); start = 1'b1;
        step();
        start = 1'b0;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 10);
            step();
            if (done) nd++;
        end
        start = 1'b0;
        chk("pulse_dones", nd, 1);

        // Enable low five cycles at bit 12
        rand_codes(); start = 1'b1;
        step();
        start = 1'b0; done_at = -1;
        for (int k = 1; k <= 45; k++) begin
            enable = !(k >= 14 && k <= 18);
            step();
            if (done && done_at < 0) done_at = k;
        end
        enable = 1'b1;
        chk("stall_latency", done_at, 39);

        // Reset at bit 20, then a clean frame
        rand_codes(); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            reset = (k == 22);
            step();
        end
        reset = 1'b0;
        chk("reset_mid_busy", {31'd0, busy}, 32'd0);
        code_a = 8'h12; code_b = 8'h34; code_c = 8'h56; code_d = 8'h78;
`ifdef IZ_SER_DEFAULT_EN
        use_default = 1'b1;
`endif
        start = 1'b1;
        step();
        start = 1'b0; use_default = 1'b0; rand_codes();
        stream = 0; nd = 0;
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k >= 2 && k <= 33) stream = {stream[30:0], serial_data_out};
            if (done) nd++;
        end
`ifdef IZ_SER_DEFAULT_EN
        chk("stream_default", stream, 32'h00A06420);
`else
        chk("stream_after_reset", stream, 32'h12345678);
`endif
        chk("after_reset_dones", nd, 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            enable      = ($urandom_range(9) != 0);
            reset       = ($urandom_range(199) == 0);
            start       = ($urandom_range(3) == 0);
            use_default = $urandom_range(1) == 1;
            rand_codes();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
